// File: rtl/socd_cleaner_mp_pkg.sv
// socd_pkg: shared types and constants for the SOCD cleaner.
//   DIR_*   : bit masks of one player's direction nibble {up,down,left,right}.
//   mode_t  : per-axis resolution mode (code 3 and codes above 5 are unused).
//   hist_t  : history register contents for the stateful modes.
//   axis_t  : axis selector used by the optional four-way stage.
package socd_pkg;

    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    typedef enum logic [2:0] {
        MODE_NEUTRAL   = 3'd0,
        MODE_FAVOR_A   = 3'd1,
        MODE_FAVOR_B   = 3'd2,
        MODE_LAST_WIN  = 3'd4,
        MODE_FIRST_WIN = 3'd5
    } mode_t;

    typedef enum logic [1:0] {
        HIST_NONE = 2'd0,
        HIST_A    = 2'd1,
        HIST_B    = 2'd2
    } hist_t;

    typedef enum logic {
        AXIS_V = 1'b0,
        AXIS_H = 1'b1
    } axis_t;

endpackage

// File: rtl/socd_cleaner_mp_axis.sv
// socd_axis: resolves one opposing pair (A = up/left, B = down/right).
// The cleaned pair is combinational from the current input and the stored
// history; the parent registers it. History and previous-input registers
// advance only on ce_i.
//   clk, rst_n : clock, asynchronous active-low reset
//   ce_i       : sample enable
//   a_i, b_i   : raw pair
//   a_o, b_o   : cleaned pair (unregistered)
//   rise_o     : either bit of the pair rose in this sample
module socd_axis
    import socd_pkg::*;
#(
    parameter mode_t MODE = MODE_NEUTRAL
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ce_i,
    input  logic a_i,
    input  logic b_i,
    output logic a_o,
    output logic b_o,
    output logic rise_o
);

    logic  prev_a_q, prev_b_q;
    hist_t hist_q, hist_d;
    logic  rise_a, rise_b;

    always_comb begin
        rise_a = a_i & ~prev_a_q;
        rise_b = b_i & ~prev_b_q;
        rise_o = rise_a | rise_b;
        hist_d = HIST_NONE;
        a_o    = a_i;
        b_o    = b_i;
        case (MODE)
            MODE_FAVOR_A: if (a_i && b_i) b_o = 1'b0;
            MODE_FAVOR_B: if (a_i && b_i) a_o = 1'b0;
            MODE_LAST_WIN: begin
                // A lone held bit always becomes the "last" one, which also
                // covers release of the opposite bit.
                if (a_i && !b_i)      hist_d = HIST_A;
                else if (b_i && !a_i) hist_d = HIST_B;
                else if (a_i && b_i) begin
                    if (rise_a && rise_b) hist_d = HIST_NONE;
                    else if (rise_a)      hist_d = HIST_A;
                    else if (rise_b)      hist_d = HIST_B;
                    else                  hist_d = hist_q;
                    a_o = (hist_d == HIST_A);
                    b_o = (hist_d == HIST_B);
                end
            end
            MODE_FIRST_WIN: begin
                if (a_i && !b_i)      hist_d = HIST_A;
                else if (b_i && !a_i) hist_d = HIST_B;
                else if (a_i && b_i) begin
                    // Both arriving together from empty has no winner.
                    hist_d = (!prev_a_q && !prev_b_q) ? HIST_NONE : hist_q;
                    a_o    = (hist_d == HIST_A);
                    b_o    = (hist_d == HIST_B);
                end
            end
            default: if (a_i && b_i) begin
                a_o = 1'b0;
                b_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_a_q <= 1'b0;
            prev_b_q <= 1'b0;
            hist_q   <= HIST_NONE;
        end else if (ce_i) begin
            prev_a_q <= a_i;
            prev_b_q <= b_i;
            hist_q   <= hist_d;
        end
    end

endmodule

// File: rtl/socd_cleaner_mp.sv
// socd_cleaner_mp: registered multi-player SOCD cleaner.
// Optional macro SOCD_FOURWAY_EN: restrict each player to a single axis,
// preferring the axis with the most recent rise.
//   clk         : core clock
//   reset_n     : asynchronous active-low reset
//   ce          : sample enable; all state holds while low
//   joy_in      : per player {up,down,left,right}, player p at [4p+3:4p]
//   joy_out     : cleaned directions, same packing, one ce-clock latency
//   socd_active : player p held an opposing pair at the last sample
module socd_cleaner_mp
    import socd_pkg::*;
#(
    parameter int    NUM_PLAYERS = 2,
    parameter mode_t V_MODE      = MODE_NEUTRAL,
    parameter mode_t H_MODE      = MODE_NEUTRAL
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     ce,
    input  logic [4*NUM_PLAYERS-1:0] joy_in,
    output logic [4*NUM_PLAYERS-1:0] joy_out,
    output logic [NUM_PLAYERS-1:0]   socd_active
);

    logic [4*NUM_PLAYERS-1:0] joy_out_q, joy_out_d;
    logic [NUM_PLAYERS-1:0]   socd_q, socd_d;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic v_a, v_b, h_a, h_b, v_rise, h_rise;

        socd_axis #(.MODE(V_MODE)) u_v (
            .clk(clk), .rst_n(reset_n), .ce_i(ce),
            .a_i(joy_in[4*p+3]), .b_i(joy_in[4*p+2]),
            .a_o(v_a), .b_o(v_b), .rise_o(v_rise)
        );

        socd_axis #(.MODE(H_MODE)) u_h (
            .clk(clk), .rst_n(reset_n), .ce_i(ce),
            .a_i(joy_in[4*p+1]), .b_i(joy_in[4*p]),
            .a_o(h_a), .b_o(h_b), .rise_o(h_rise)
        );

        assign socd_d[p] = (joy_in[4*p+3] & joy_in[4*p+2]) |
                           (joy_in[4*p+1] & joy_in[4*p]);

`ifdef SOCD_FOURWAY_EN
        axis_t sel_q, sel_d;
        logic  v_any, h_any;

        always_comb begin
            v_any = v_a | v_b;
            h_any = h_a | h_b;
            sel_d = sel_q;
            // A rise on exactly one axis moves the selection; a lone
            // surviving axis always wins and claims the selection.
            if (v_rise && !h_rise)      sel_d = AXIS_V;
            else if (h_rise && !v_rise) sel_d = AXIS_H;
            if (v_any && !h_any)        sel_d = AXIS_V;
            else if (h_any && !v_any)   sel_d = AXIS_H;
        end

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n)  sel_q <= AXIS_V;
            else if (ce)   sel_q <= sel_d;
        end

        assign joy_out_d[4*p +: 4] = (sel_d == AXIS_V) ? {v_a, v_b, 2'b00}
                                                       : {2'b00, h_a, h_b};
`else
        logic unused_rise;
        assign unused_rise = v_rise ^ h_rise;
        assign joy_out_d[4*p +: 4] = {v_a, v_b, h_a, h_b};
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joy_out_q <= '0;
            socd_q    <= '0;
        end else if (ce) begin
            joy_out_q <= joy_out_d;
            socd_q    <= socd_d;
        end
    end

    assign joy_out     = joy_out_q;
    assign socd_active = socd_q;

endmodule
